// File: rtl/lc3_pkg.sv
// Shared LC-3 decode definitions: opcodes, instruction field positions,
// decode FSM state encoding and the condition-code helper.
package lc3_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned NZP_W  = 3;
    localparam int unsigned CNT_W  = 3;

    localparam logic [OPC_W-1:0] OP_BR  = 4'b0000;
    localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OPC_W-1:0] OP_LD  = 4'b0010;
    localparam logic [OPC_W-1:0] OP_ST  = 4'b0011;
    localparam logic [OPC_W-1:0] OP_JSR = 4'b0100;
    localparam logic [OPC_W-1:0] OP_AND = 4'b0101;
    localparam logic [OPC_W-1:0] OP_LDR = 4'b0110;
    localparam logic [OPC_W-1:0] OP_STR = 4'b0111;
    localparam logic [OPC_W-1:0] OP_RTI = 4'b1000;
    localparam logic [OPC_W-1:0] OP_NOT = 4'b1001;
    localparam logic [OPC_W-1:0] OP_LDI = 4'b1010;
    localparam logic [OPC_W-1:0] OP_STI = 4'b1011;
    localparam logic [OPC_W-1:0] OP_JMP = 4'b1100;
    localparam logic [OPC_W-1:0] OP_RSV = 4'b1101;
    localparam logic [OPC_W-1:0] OP_LEA = 4'b1110;
    localparam logic [OPC_W-1:0] OP_TRP = 4'b1111;

    localparam logic [NZP_W-1:0] CC_RESET = 3'b010;

    // Instruction field bit positions
    localparam int unsigned OPC_MSB   = 15;
    localparam int unsigned OPC_LSB   = 12;
    localparam int unsigned DR_MSB    = 11;
    localparam int unsigned DR_LSB    = 9;
    localparam int unsigned SR1_MSB   = 8;
    localparam int unsigned SR1_LSB   = 6;
    localparam int unsigned SR2_MSB   = 2;
    localparam int unsigned SR2_LSB   = 0;
    localparam int unsigned IMM_FLAG  = 5;
    localparam int unsigned IMM5_MSB  = 4;
    localparam int unsigned OFF9_MSB  = 8;
    localparam int unsigned OFF11_MSB = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dec_state_e;

    // Condition codes {N,Z,P} for a value written to the register file
    function automatic logic [NZP_W-1:0] cc_of(input logic [WORD_W-1:0] v);
        logic n;
        logic z;
        n = v[WORD_W-1];
        z = (v == '0);
        return {n, z, ~n & ~z};
    endfunction

endpackage

// File: rtl/cc_reg.sv
// NZP condition-code register; loads from the writeback value on cc_we.
module cc_reg
    import lc3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cc_we,
    input  logic [WORD_W-1:0] cc_data,
    output logic [NZP_W-1:0]  nzp
);

    logic [NZP_W-1:0] nzp_q;
    logic [NZP_W-1:0] nzp_d;

    always_comb begin
        nzp_d = nzp_q;
        if (cc_we) begin
            nzp_d = cc_of(cc_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nzp_q <= CC_RESET;
        end else begin
            nzp_q <= nzp_d;
        end
    end

    assign nzp = nzp_q;

endmodule

// File: rtl/decode_ir.sv
// LC-3 instruction register / decode stage: waits out the memory read
// latency after decode_start, latches the word into IR and exposes its fields.
module decode_ir
    import lc3_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              decode_start,
    input  logic [WORD_W-1:0] mem_dout,
    input  logic              cc_we,
    input  logic [WORD_W-1:0] cc_data,
    output logic [WORD_W-1:0] ir,
    output logic [3:0]        opCode_out,
    output logic [8:0]        offset_out,
    output logic [10:0]       off11_out,
    output logic [2:0]        br_nzp,
    output logic [2:0]        dr,
    output logic [2:0]        sr1,
    output logic [2:0]        sr2,
    output logic              imm_flag,
    output logic [WORD_W-1:0] imm16,
    output logic [NZP_W-1:0]  result_nzp,
    output logic              busy,
    output logic              decode_done,
    output logic              illegal
);

    dec_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] ir_q;
    logic              busy_q;
    logic              done_q;
    logic              illegal_q;

    // Decode FSM; busy/done/illegal are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ir_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (decode_start) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= CNT_W'(MEM_LAT - 1);
                        busy_q  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        ir_q      <= mem_dout;
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        illegal_q <= (mem_dout[OPC_MSB:OPC_LSB] == OP_RSV);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    cc_reg u_cc_reg (
        .clk     (clk),
        .rst     (rst),
        .cc_we   (cc_we),
        .cc_data (cc_data),
        .nzp     (result_nzp)
    );

    assign ir          = ir_q;
    assign opCode_out  = ir_q[OPC_MSB:OPC_LSB];
    assign offset_out  = ir_q[OFF9_MSB:0];
    assign off11_out   = ir_q[OFF11_MSB:0];
    assign br_nzp      = ir_q[DR_MSB:DR_LSB];
    assign dr          = ir_q[DR_MSB:DR_LSB];
    assign sr1         = ir_q[SR1_MSB:SR1_LSB];
    assign sr2         = ir_q[SR2_MSB:SR2_LSB];
    assign imm_flag    = ir_q[IMM_FLAG];
    assign imm16       = {{(WORD_W-IMM5_MSB-1){ir_q[IMM5_MSB]}}, ir_q[IMM5_MSB:0]};
    assign busy        = busy_q;
    assign decode_done = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_decode_ir.sv
// Bench for decode_ir: transaction-level model checked every cycle, plus
// directed decodes, condition-code, ignore and abort scenarios.
module tb_decode_ir;

    localparam int unsigned MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        decode_start = 1'b0;
    logic [15:0] mem_dout = 16'h0000;
    logic        cc_we = 1'b0;
    logic [15:0] cc_data = 16'h0000;

    logic [15:0] ir;
    logic [3:0]  opCode_out;
    logic [8:0]  offset_out;
    logic [10:0] off11_out;
    logic [2:0]  br_nzp, dr, sr1, sr2;
    logic        imm_flag;
    logic [15:0] imm16;
    logic [2:0]  result_nzp;
    logic        busy, decode_done, illegal;

    decode_ir #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst), .decode_start(decode_start), .mem_dout(mem_dout),
        .cc_we(cc_we), .cc_data(cc_data), .ir(ir), .opCode_out(opCode_out),
        .offset_out(offset_out), .off11_out(off11_out), .br_nzp(br_nzp),
        .dr(dr), .sr1(sr1), .sr2(sr2), .imm_flag(imm_flag), .imm16(imm16),
        .result_nzp(result_nzp), .busy(busy), .decode_done(decode_done),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted fetch is remembered by its start edge number
    int          edge_n   = 0;
    int          m_e      = 0;
    bit          m_active = 1'b0;
    logic [15:0] m_ir     = 16'h0000;
    logic [2:0]  m_nzp    = 3'b010;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_active = 1'b0;
            m_ir     = 16'h0000;
            m_nzp    = 3'b010;
        end else begin
            if (cc_we) begin
                if ($signed(cc_data) < 0)  m_nzp = 3'b100;
                else if (cc_data == 0)     m_nzp = 3'b010;
                else                       m_nzp = 3'b001;
            end
            if (m_active && edge_n == m_e + int'(MEM_LAT)) m_ir = mem_dout;
            if (decode_start && (!m_active || edge_n >= m_e + int'(MEM_LAT) + 2)) begin
                m_active = 1'b1;
                m_e      = edge_n;
            end
        end
    end

    // Per-cycle comparison against the model, sampled after outputs settle
    always @(posedge clk) begin
        int   imm;
        logic e_busy, e_done;
        #2;
        e_busy = m_active && edge_n <= m_e + int'(MEM_LAT);
        e_done = m_active && edge_n == m_e + int'(MEM_LAT);
        imm = int'(m_ir % 32);
        if (imm >= 16) imm = imm - 32;
        if (decode_done === 1'b1) done_cnt++;
        chk("ir", ir, m_ir);
        chk("opcode", 16'(opCode_out), 16'(m_ir / 4096));
        chk("offset9", 16'(offset_out), 16'(m_ir % 512));
        chk("offset11", 16'(off11_out), 16'(m_ir % 2048));
        chk("br_nzp", 16'(br_nzp), 16'((m_ir / 512) % 8));
        chk("dr", 16'(dr), 16'((m_ir / 512) % 8));
        chk("sr1", 16'(sr1), 16'((m_ir / 64) % 8));
        chk("sr2", 16'(sr2), 16'(m_ir % 8));
        chk("imm_flag", 16'(imm_flag), 16'((m_ir / 32) % 2));
        chk("imm16", imm16, 16'(imm));
        chk("result_nzp", 16'(result_nzp), 16'(m_nzp));
        chk("busy", 16'(busy), 16'(e_busy));
        chk("decode_done", 16'(decode_done), 16'(e_done));
        chk("illegal", 16'(illegal), 16'(e_done && (m_ir / 4096) == 13));
    end

    // Issue a fetch and return positioned in the decode_done cycle
    task automatic fetch(input logic [15:0] w);
        @(negedge clk);
        decode_start = 1'b1;
        mem_dout     = w;
        @(negedge clk);
        decode_start = 1'b0;
        repeat (MEM_LAT) @(negedge clk);
    endtask

    task automatic cc_write(input logic [15:0] v);
        @(negedge clk);
        cc_we   = 1'b1;
        cc_data = v;
        @(negedge clk);
        cc_we   = 1'b0;
    endtask

    initial begin
        int d0;
        // Reset
        repeat (5) @(negedge clk);
        rst = 1'b0;
        chk("rst_ir", ir, 16'h0000);
        chk("rst_opcode", 16'(opCode_out), 16'h0);
        chk("rst_br_nzp", 16'(br_nzp), 16'h0);
        chk("rst_nzp", 16'(result_nzp), 16'h0002);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_done", 16'(decode_done), 16'h0);

        // BRn
        fetch(16'h0805);
        chk("brn_done", 16'(decode_done), 16'h1);
        chk("brn_ir", ir, 16'h0805);
        chk("brn_nzp", 16'(br_nzp), 16'h0004);
        chk("brn_off", 16'(offset_out), 16'h0005);
        chk("brn_illegal", 16'(illegal), 16'h0);
        @(negedge clk);
        chk("brn_done_drop", 16'(decode_done), 16'h0);

        // ADD R1,R2,#-3
        fetch(16'h12BD);
        chk("add_op", 16'(opCode_out), 16'h0001);
        chk("add_dr", 16'(dr), 16'h0001);
        chk("add_sr1", 16'(sr1), 16'h0002);
        chk("add_imm_flag", 16'(imm_flag), 16'h0001);
        chk("add_imm16", imm16, 16'hFFFD);

        // Reserved opcode
        fetch(16'hD000);
        chk("rsv_done", 16'(decode_done), 16'h1);
        chk("rsv_illegal", 16'(illegal), 16'h1);
        @(negedge clk);
        chk("rsv_illegal_drop", 16'(illegal), 16'h0);

        // Condition codes
        cc_write(16'h8000);
        chk("cc_neg", 16'(result_nzp), 16'h0004);
        cc_write(16'h0000);
        chk("cc_zero", 16'(result_nzp), 16'h0002);
        cc_write(16'h0005);
        chk("cc_pos", 16'(result_nzp), 16'h0001);

        // CC write on the IR latch edge
        @(negedge clk);
        decode_start = 1'b1;
        mem_dout     = 16'h3A41;
        @(negedge clk);
        decode_start = 1'b0;
        repeat (MEM_LAT - 1) @(negedge clk);
        cc_we   = 1'b1;
        cc_data = 16'hF000;
        @(negedge clk);
        cc_we    = 1'b0;
        mem_dout = 16'hFFFF;
        chk("same_edge_ir", ir, 16'h3A41);
        chk("same_edge_nzp", 16'(result_nzp), 16'h0004);
        chk("same_edge_done", 16'(decode_done), 16'h1);

        // Second start while busy is ignored
        @(negedge clk);
        d0 = done_cnt;
        decode_start = 1'b1;
        mem_dout     = 16'h5123;
        @(negedge clk);
        @(negedge clk);
        decode_start = 1'b0;
        repeat (8) @(negedge clk);
        chk("ignore_one_done", 16'(done_cnt - d0), 16'h0001);
        chk("ignore_ir", ir, 16'h5123);

        // Reset mid-WAIT aborts the fetch
        d0 = done_cnt;
        @(negedge clk);
        decode_start = 1'b1;
        mem_dout     = 16'h4ABC;
        @(negedge clk);
        decode_start = 1'b0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_done", 16'(done_cnt - d0), 16'h0000);
        chk("abort_ir", ir, 16'h0000);
        chk("abort_nzp", 16'(result_nzp), 16'h0002);
        fetch(16'hE1F0);
        chk("after_abort_ir", ir, 16'hE1F0);
        chk("after_abort_done", 16'(decode_done), 16'h1);

        // Randomized traffic, including starts while busy and occasional resets
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            decode_start = ($urandom_range(0, 2) == 0);
            mem_dout     = 16'($urandom);
            cc_we        = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       cc_data = 16'h0000;
                1:       cc_data = 16'h8000;
                default: cc_data = 16'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) mem_dout[15:12] = 4'hD;
            rst = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        decode_start = 1'b0;
        cc_we        = 1'b0;
        rst          = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_ir.md
Name: decode_ir

Overview:
- LC-3 instruction-register / decode stage; the consumer end of the fetch interface.
- The fetch unit drives the memory address (pc) and issues the read. This block waits out the memory read latency, latches the returned word into IR, and splits it into the fields fetch consumes (opCode_in, offset_in, br_nzp).
- Also owns the NZP condition-code register that feeds fetch's result_nzp input.
- Sits between instruction BRAM data out and fetch/execute.

Parameters:
- MEM_LAT, 2, memory read latency in clk cycles from decode_start to valid mem_dout; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- decode_start  input  1  one-cycle pulse: fetch has issued the read at pc.
- mem_dout  input  16  instruction word from memory.
- cc_we  input  1  writeback strobe; updates condition codes.
- cc_data  input  16  value being written to the register file.
- ir  output  16  latched instruction.
- opCode_out  output  4  ir[15:12]; drives fetch opCode_in.
- offset_out  output  9  ir[8:0], PCoffset9; drives fetch offset_in.
- off11_out  output  11  ir[10:0], JSR PCoffset11.
- br_nzp  output  3  ir[11:9], branch condition mask.
- dr  output  3  ir[11:9], destination register.
- sr1  output  3  ir[8:6], source/base register.
- sr2  output  3  ir[2:0].
- imm_flag  output  1  ir[5].
- imm16  output  16  ir[4:0] sign-extended to 16 bits.
- result_nzp  output  3  condition codes {N,Z,P}.
- busy  output  1  high in WAIT and DONE.
- decode_done  output  1  one-cycle pulse: IR and fields are valid.
- illegal  output  1  pulses with decode_done when opCode_out == 4'b1101.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, latency counter=0, ir=16'h0000 (BR nzp=000, a NOP).
  - result_nzp=3'b010, decode_done=0, illegal=0, busy=0.
  - All field outputs follow ir, so all are 0.
- Field outputs are combinational slices of ir. They are stable between latches.
- FSM states IDLE, WAIT, DONE; Moore outputs.
  - IDLE: when decode_start=1 at a rising edge, go to WAIT and set cnt=MEM_LAT-1.
  - WAIT: at each edge, if cnt==0, then ir<=mem_dout and go to DONE; else cnt<=cnt-1.
  - DONE: decode_done=1; illegal=(ir[15:12]==4'b1101). Next edge returns to IDLE.
- Latency:
  - start sampled at edge E; ir loads at edge E+MEM_LAT.
  - decode_done is high for exactly the cycle after E+MEM_LAT.
  - Minimum spacing between accepted starts is MEM_LAT+2 cycles.
- decode_start while busy=1 is ignored (not queued). decode_start in the DONE cycle is also ignored.
- mem_dout is sampled only at the latch edge. Changes at other times have no effect.
- Condition-code register (independent of the FSM; updates in any state):
  - On an edge with cc_we=1: N=cc_data[15]; Z=(cc_data==0); P=~N & ~Z.
  - Exactly one bit is always set.
  - cc_we and a latch on the same edge both take effect.
- Reset asserted mid-WAIT or mid-DONE:
  - Immediate return to the reset values; no decode_done is produced for that fetch.
  - After rst deasserts, the block waits in IDLE for a fresh decode_start.
- imm16 = {{11{ir[4]}}, ir[4:0]}.

Decomposition:
- lc3_pkg:
  - opcode localparams (OP_BR=4'b0000, OP_ADD=4'b0001, OP_JSR=4'b0100, OP_RSV=4'b1101, ...).
  - FSM state encoding (2 bits).
  - CC_RESET=3'b010.
  - Field bit-position constants.
- One sub-module, cc_reg:
  - NZP register with cc_we/cc_data input and async active-high reset.
  - Reused later by the execute stage.

Test Plan:
- Reset check:
  - Stimulus: hold rst=1 for 5 cycles, release.
  - Required: ir=0, opCode_out=0, br_nzp=0, result_nzp=3'b010, busy=0, decode_done=0.
- BRn decode, MEM_LAT=2:
  - Stimulus: pulse decode_start at edge 0; drive mem_dout=16'h0805.
  - Required: ir=16'h0805 after edge 2; decode_done high only in cycle 3; opCode_out=4'b0000; br_nzp=3'b100; offset_out=9'h005; illegal=0.
- ADD immediate decode:
  - Stimulus: mem_dout=16'h12BD (ADD R1,R2,#-3).
  - Required: opCode_out=4'b0001, dr=1, sr1=2, imm_flag=1, imm16=16'hFFFD.
- Reserved opcode:
  - Stimulus: mem_dout=16'hD000.
  - Required: illegal=1 in the same single cycle as decode_done.
- Condition codes:
  - Stimulus: cc_we with cc_data=16'h8000, then 16'h0000, then 16'h0005.
  - Required: result_nzp=100, then 010, then 001. Also repeat one update on the same edge as the IR latch; both take effect.
- Ignore and abort:
  - Stimulus: second decode_start one cycle after the first.
  - Required: exactly one decode_done.
  - Stimulus: assert rst mid-WAIT.
  - Required: no decode_done, ir=0, result_nzp=010. A later decode_start decodes normally.
